// File: rtl/uart_ctrl.sv
// UART controller on the IO interconnect: MMIO register window, RX/TX FIFOs,
// programmable frame format, 16x-oversampled receiver and maskable level interrupt.

module uart_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (count_r == (AW+1)'(0));
    assign full      = (count_r == (AW+1)'(DEPTH));
    // A push on full is only accepted when the same cycle frees a slot.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (do_push_s & ~do_pop_s) begin
                count_r <= count_r + (AW+1)'(1);
            end else if (do_pop_s & ~do_push_s) begin
                count_r <= count_r - (AW+1)'(1);
            end
        end
    end
endmodule

module uart_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          FIFO_AW     = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_bus_s_rd_en,
    input  logic        io_bus_s_wr_en,
    input  logic [31:0] io_bus_s_address,
    input  logic [31:0] io_bus_s_wr_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [31:0] rd_data,
    output logic        irq
);
    localparam logic [7:0] OFF_RXDATA = 8'h00;
    localparam logic [7:0] OFF_TXDATA = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_CTRL   = 8'h0C;
    localparam logic [7:0] OFF_IE     = 8'h10;
    localparam logic [7:0] OFF_ERRCLR = 8'h14;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Parity bit for the low 5..8 bits of data; odd mode (2'b10) inverts the XOR.
    function automatic logic parity_of(input logic [7:0] data, input logic [1:0] bits_code,
                                       input logic [1:0] mode);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - bits_code);
        return (^(data & mask)) ^ (mode == 2'b10);
    endfunction

    logic              cs_s, rd_s, wr_s;
    logic [7:0]        off_s;
    logic              tx_push_s, ctrl_wr_s, ie_wr_s;
    logic [2:0]        errclr_s;
    logic [31:0]       rd_mux_s, status_s;
    logic              unused_s;

    logic [20:0]       ctrl_r;
    logic [2:0]        ie_r;
    logic [31:0]       rd_data_r;
    logic              irq_r;
    logic              par_err_r, frm_err_r, ovr_r;

    logic [15:0]       div_cnt_r;
    logic              tick_s;

    logic [7:0]        tx_head_s, rx_head_s;
    logic [FIFO_AW:0]  tx_count_s, rx_count_s;
    logic              tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
    logic              tx_pop_s, rx_pop_s;

    tx_state_t         tx_state_r;
    logic              tx_line_r;
    logic [3:0]        tx_tcnt_r;
    logic [2:0]        tx_idx_r;
    logic [7:0]        tx_shift_r;
    logic [1:0]        tx_bits_r, tx_mode_r;
    logic              tx_stop2_r, tx_par_bit_r;
    logic              tx_bit_end_s, tx_last_s;

    rx_state_t         rx_state_r;
    logic              rx_meta_r, rx_sync_r;
    logic [3:0]        rx_tcnt_r;
    logic [2:0]        rx_idx_r;
    logic [7:0]        rx_data_r;
    logic [1:0]        rx_bits_r, rx_mode_r;
    logic              rx_par_r;
    logic              rx_sample_s, rx_done_s, rx_par_ok_s;
    logic              par_set_s, frm_set_s, ovr_set_s;

    assign cs_s      = (io_bus_s_address[31:8] == BASE_ADDR[31:8]);
    assign off_s     = io_bus_s_address[7:0];
    assign rd_s      = io_bus_s_rd_en & cs_s;
    assign wr_s      = io_bus_s_wr_en & cs_s;
    assign tx_push_s = wr_s & (off_s == OFF_TXDATA);
    assign ctrl_wr_s = wr_s & (off_s == OFF_CTRL);
    assign ie_wr_s   = wr_s & (off_s == OFF_IE);
    assign errclr_s  = (wr_s & (off_s == OFF_ERRCLR)) ? io_bus_s_wr_data[7:5] : 3'b000;
    assign rx_pop_s  = rd_s & (off_s == OFF_RXDATA) & ~rx_empty_s;
    assign unused_s  = ^io_bus_s_wr_data[31:21];

    assign status_s = {8'h00, 8'(tx_count_s), 8'(rx_count_s), ovr_r, frm_err_r, par_err_r,
                       (tx_state_r != TX_IDLE), tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};

    uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push_s), .push_data(io_bus_s_wr_data[7:0]),
        .pop(tx_pop_s), .head(tx_head_s), .count(tx_count_s), .empty(tx_empty_s), .full(tx_full_s)
    );

    uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_done_s), .push_data(rx_data_r),
        .pop(rx_pop_s), .head(rx_head_s), .count(rx_count_s), .empty(rx_empty_s), .full(rx_full_s)
    );

    // Read data selection for the addressed register.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (off_s)
            OFF_RXDATA: begin
                if (rx_empty_s) begin
                    rd_mux_s = 32'h0000_0000;
                end else begin
                    rd_mux_s = {24'h00_0000, rx_head_s};
                end
            end
            OFF_STATUS: rd_mux_s = status_s;
            OFF_CTRL:   rd_mux_s = {11'h000, ctrl_r};
            OFF_IE:     rd_mux_s = {29'h0000_0000, ie_r};
            default:    rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Host registers, read data, sticky error flags and interrupt; a set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r    <= {1'b0, 2'b00, 2'b11, DEFAULT_DIV};
            ie_r      <= 3'b000;
            rd_data_r <= 32'h0000_0000;
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
            ovr_r     <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                ctrl_r <= io_bus_s_wr_data[20:0];
            end
            if (ie_wr_s) begin
                ie_r <= io_bus_s_wr_data[2:0];
            end
            if (rd_s) begin
                rd_data_r <= rd_mux_s;
            end
            par_err_r <= par_set_s | (par_err_r & ~errclr_s[0]);
            frm_err_r <= frm_set_s | (frm_err_r & ~errclr_s[1]);
            ovr_r     <= ovr_set_s | (ovr_r & ~errclr_s[2]);
            irq_r     <= (ie_r[0] & ~rx_empty_s) | (ie_r[1] & tx_empty_s) |
                         (ie_r[2] & (par_err_r | frm_err_r | ovr_r));
        end
    end

    assign tick_s = (div_cnt_r == ctrl_r[15:0]);

    // Oversample tick counter; restarted by CTRL writes so a new divisor starts cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= 16'h0000;
        end else if (ctrl_wr_s || tick_s) begin
            div_cnt_r <= 16'h0000;
        end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
        end
    end

    assign tx_bit_end_s = tick_s & (tx_tcnt_r == 4'd15);
    assign tx_last_s    = tx_bit_end_s & (((tx_state_r == TX_STOP1) & ~tx_stop2_r) |
                                          (tx_state_r == TX_STOP2));
    // Frames start on a tick so every bit spans exactly 16 ticks.
    assign tx_pop_s     = ~tx_empty_s & (((tx_state_r == TX_IDLE) & tick_s) | tx_last_s);

    // Transmit sequencer; the serial line is registered and changes on bit boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r   <= TX_IDLE;
            tx_line_r    <= 1'b1;
            tx_tcnt_r    <= 4'd0;
            tx_idx_r     <= 3'd0;
            tx_shift_r   <= 8'h00;
            tx_bits_r    <= 2'b11;
            tx_mode_r    <= 2'b00;
            tx_stop2_r   <= 1'b0;
            tx_par_bit_r <= 1'b0;
        end else begin
            if (tick_s) begin
                tx_tcnt_r <= tx_tcnt_r + 4'd1;
            end
            if (tx_pop_s) begin
                tx_state_r   <= TX_START;
                tx_line_r    <= 1'b0;
                tx_tcnt_r    <= 4'd0;
                tx_shift_r   <= tx_head_s;
                tx_bits_r    <= ctrl_r[17:16];
                tx_mode_r    <= ctrl_r[19:18];
                tx_stop2_r   <= ctrl_r[20];
                tx_par_bit_r <= parity_of(tx_head_s, ctrl_r[17:16], ctrl_r[19:18]);
            end else if (tx_bit_end_s) begin
                case (tx_state_r)
                    TX_START: begin
                        tx_state_r <= TX_DATA;
                        tx_line_r  <= tx_shift_r[0];
                        tx_idx_r   <= 3'd0;
                    end
                    TX_DATA: begin
                        if (tx_idx_r == (3'd4 + {1'b0, tx_bits_r})) begin
                            if (^tx_mode_r) begin
                                tx_state_r <= TX_PARITY;
                                tx_line_r  <= tx_par_bit_r;
                            end else begin
                                tx_state_r <= TX_STOP1;
                                tx_line_r  <= 1'b1;
                            end
                        end else begin
                            tx_idx_r   <= tx_idx_r + 3'd1;
                            tx_shift_r <= tx_shift_r >> 1;
                            tx_line_r  <= tx_shift_r[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state_r <= TX_STOP1;
                        tx_line_r  <= 1'b1;
                    end
                    TX_STOP1: begin
                        tx_state_r <= tx_stop2_r ? TX_STOP2 : TX_IDLE;
                        tx_line_r  <= 1'b1;
                    end
                    default: begin
                        tx_state_r <= TX_IDLE;
                        tx_line_r  <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_sample_s = tick_s & (rx_tcnt_r == ((rx_state_r == RX_START) ? 4'd7 : 4'd15));
    assign rx_done_s   = rx_sample_s & (rx_state_r == RX_STOP);
    assign rx_par_ok_s = ~(^rx_mode_r) | (parity_of(rx_data_r, rx_bits_r, rx_mode_r) == rx_par_r);
    assign par_set_s   = rx_done_s & ~rx_par_ok_s;
    assign frm_set_s   = rx_done_s & ~rx_sync_r;
    assign ovr_set_s   = rx_done_s & rx_full_s & ~rx_pop_s;

    // Receive sequencer: mid-bit sampling, 8 ticks after the start edge then every 16.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            rx_tcnt_r  <= 4'd0;
            rx_idx_r   <= 3'd0;
            rx_data_r  <= 8'h00;
            rx_bits_r  <= 2'b11;
            rx_mode_r  <= 2'b00;
            rx_par_r   <= 1'b0;
        end else begin
            if (tick_s) begin
                rx_tcnt_r <= rx_tcnt_r + 4'd1;
            end
            case (rx_state_r)
                RX_IDLE: begin
                    if (!rx_sync_r) begin
                        rx_state_r <= RX_START;
                        rx_tcnt_r  <= 4'd0;
                        rx_data_r  <= 8'h00;
                        rx_bits_r  <= ctrl_r[17:16];
                        rx_mode_r  <= ctrl_r[19:18];
                    end
                end
                RX_START: begin
                    if (rx_sample_s) begin
                        rx_tcnt_r  <= 4'd0;
                        rx_idx_r   <= 3'd0;
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_sample_s) begin
                        rx_data_r[rx_idx_r] <= rx_sync_r;
                        if (rx_idx_r == (3'd4 + {1'b0, rx_bits_r})) begin
                            rx_state_r <= (^rx_mode_r) ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_idx_r <= rx_idx_r + 3'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_sample_s) begin
                        rx_par_r   <= rx_sync_r;
                        rx_state_r <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_sample_s) begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    assign uart_tx = tx_line_r;
    assign rd_data = rd_data_r;
    assign irq     = irq_r;
endmodule

// File: tb/tb_uart_ctrl.sv
// Directed-plus-random bench for uart_ctrl: serial frames are predicted from the
// frame rules and received bytes are tracked in a queue model.

module tb_uart_ctrl;
    localparam logic [31:0] BASE   = 32'h0000_2000;
    localparam logic [31:0] A_RX   = BASE + 32'h00;
    localparam logic [31:0] A_TX   = BASE + 32'h04;
    localparam logic [31:0] A_ST   = BASE + 32'h08;
    localparam logic [31:0] A_CTRL = BASE + 32'h0C;
    localparam logic [31:0] A_IE   = BASE + 32'h10;
    localparam logic [31:0] A_CLR  = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rx_drv = 1'b1;
    logic        loopback = 1'b0;
    logic        uart_rx, uart_tx, irq;
    logic [31:0] rd_data;

    int errors = 0;
    int checks = 0;
    int bit_clk = 64;
    logic [7:0] rx_model[$];

    assign uart_rx = loopback ? uart_tx : rx_drv;
    always #5 clk = ~clk;

    uart_ctrl dut (
        .clk(clk), .rst(rst), .io_bus_s_rd_en(rd_en), .io_bus_s_wr_en(wr_en),
        .io_bus_s_address(addr), .io_bus_s_wr_data(wdata), .uart_rx(uart_rx),
        .uart_tx(uart_tx), .rd_data(rd_data), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
    endtask

    function automatic logic [7:0] dmask(input int db);
        return 8'((32'd1 << db) - 32'd1);
    endfunction

    task automatic set_fmt(input int div, input int db, input int pm, input bit s2);
        logic [31:0] v;
        v = {11'd0, s2, 2'(pm), 2'(db - 5), 16'(div)};
        bus_write(A_CTRL, v);
        bit_clk = 16 * (div + 1);
    endtask

    // Expected line sequence: start, data LSB first, optional parity, stop bit(s).
    task automatic tx_expect(input logic [7:0] d, input int db, input int pm, input bit s2);
        logic exp_q[$];
        logic p;
        int n;
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < db; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pm == 1) exp_q.push_back(p);
        else if (pm == 2) exp_q.push_back(~p);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
        n = 0;
        while (uart_tx !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", {31'h0, (n < 5000)}, 32'h1);
        if (n < 5000) begin
            repeat (bit_clk / 2) @(negedge clk);
            foreach (exp_q[i]) begin
                check($sformatf("tx_bit%0d", i), {31'h0, uart_tx}, {31'h0, exp_q[i]});
                repeat (bit_clk) @(negedge clk);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int db, input int pm, input bit s2,
                              input bit bad_par, input bit bad_stop);
        logic p;
        p = 1'b0;
        rx_drv = 1'b0;
        repeat (bit_clk) @(negedge clk);
        for (int i = 0; i < db; i++) begin
            rx_drv = d[i];
            p = p ^ d[i];
            repeat (bit_clk) @(negedge clk);
        end
        if (pm == 1 || pm == 2) begin
            rx_drv = ((pm == 2) ? ~p : p) ^ bad_par;
            repeat (bit_clk) @(negedge clk);
        end
        if (bad_stop) begin
            // Low only across the sample point, so the line is idle before a new start is judged.
            rx_drv = 1'b0;
            repeat (bit_clk * 3 / 4) @(negedge clk);
            rx_drv = 1'b1;
            repeat (bit_clk / 4) @(negedge clk);
        end else begin
            rx_drv = 1'b1;
            repeat (bit_clk) @(negedge clk);
        end
        if (s2) repeat (bit_clk) @(negedge clk);
        rx_drv = 1'b1;
        repeat (bit_clk) @(negedge clk);
    endtask

    task automatic wait_rx_count(input int target, input int max_polls);
        logic [31:0] s;
        int n;
        n = 0;
        bus_read(A_ST, s);
        while (s[15:8] != target[7:0] && n < max_polls) begin
            repeat (8) @(negedge clk);
            bus_read(A_ST, s);
            n++;
        end
        check("rx_count_reached", {24'h0, s[15:8]}, {24'h0, target[7:0]});
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        logic [7:0]  trip[3];
        int db, pm, lows;
        bit s2;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", {31'h0, uart_tx}, 32'h1);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        bus_read(A_ST, r);   check("reset_status", r, 32'h0000_0005);
        bus_read(A_CTRL, r); check("reset_ctrl", r, 32'h0003_0145);
        bus_read(A_IE, r);   check("reset_ie", r, 32'h0);

        // Off-window and undefined accesses.
        bus_write(BASE + 32'h104, 32'h55);
        bus_read(A_ST, r);   check("cs_low_no_push", r, 32'h0000_0005);
        bus_read(BASE + 32'h18, r); check("undef_read", r, 32'h0);
        bus_read(A_TX, r);   check("wo_read", r, 32'h0);

        // 8N1 0xA5 at divisor 3.
        set_fmt(3, 8, 0, 0);
        bus_read(A_CTRL, r); check("ctrl_rb", r, 32'h0003_0003);
        bus_write(A_TX, 32'hA5);
        tx_expect(8'hA5, 8, 0, 0);
        bus_read(A_ST, r);   check("tx_done_status", r, 32'h0000_0005);

        // Random formats on the transmitter.
        for (int k = 0; k < 4; k++) begin
            db = $urandom_range(5, 8);
            pm = $urandom_range(0, 3);
            s2 = 1'($urandom_range(0, 1));
            b  = 8'($urandom);
            set_fmt(3, db, pm, s2);
            bus_write(A_TX, {24'h0, b});
            tx_expect(b, db, pm, s2);
        end

        // Random loopback frames.
        loopback = 1'b1;
        for (int k = 0; k < 4; k++) begin
            db = $urandom_range(5, 8);
            pm = $urandom_range(0, 3);
            s2 = 1'($urandom_range(0, 1));
            b  = 8'($urandom);
            set_fmt(3, db, pm, s2);
            bus_write(A_TX, {24'h0, b});
            wait_rx_count(1, 1000);
            repeat (3 * bit_clk) @(negedge clk);
            bus_read(A_RX, r);  check("loop_rand_data", r, {24'h0, b & dmask(db)});
            bus_read(A_ST, r);  check("loop_rand_status", r, 32'h0000_0005);
        end

        // 7E2 loopback, back-to-back frames.
        set_fmt(3, 7, 1, 1);
        trip[0] = 8'h55; trip[1] = 8'h2A; trip[2] = 8'h7F;
        for (int k = 0; k < 3; k++) bus_write(A_TX, {24'h0, trip[k]});
        wait_rx_count(3, 1000);
        repeat (2 * bit_clk) @(negedge clk);
        bus_read(A_ST, r);   check("loop_7e2_status", r, 32'h0000_0304);
        for (int k = 0; k < 3; k++) begin
            bus_read(A_RX, r); check("loop_7e2_data", r, {24'h0, trip[k] & dmask(7)});
        end
        bus_read(A_ST, r);   check("loop_7e2_drained", r, 32'h0000_0005);
        loopback = 1'b0;

        // 8O1 with the parity bit flipped from its correct value.
        set_fmt(3, 8, 2, 0);
        bus_write(A_IE, 32'h4);
        send_frame(8'h01, 8, 2, 0, 1'b1, 1'b0);
        bus_read(A_ST, r);   check("par_err_status", r, 32'h0000_0124);
        check("par_err_irq", {31'h0, irq}, 32'h1);
        bus_read(A_RX, r);   check("par_err_data", r, 32'h01);
        bus_write(A_CLR, 32'h20);
        repeat (2) @(negedge clk);
        check("par_clr_irq", {31'h0, irq}, 32'h0);
        bus_read(A_ST, r);   check("par_clr_status", r, 32'h0000_0005);

        // One-tick glitch, then a good frame, then a bad stop bit.
        set_fmt(3, 8, 0, 0);
        rx_drv = 1'b0;
        repeat (bit_clk / 16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * bit_clk) @(negedge clk);
        bus_read(A_ST, r);   check("glitch_status", r, 32'h0000_0005);
        send_frame(8'h3C, 8, 0, 0, 1'b0, 1'b0);
        bus_read(A_ST, r);   check("after_glitch_status", r, 32'h0000_0104);
        bus_read(A_RX, r);   check("after_glitch_data", r, 32'h3C);
        send_frame(8'hC3, 8, 0, 0, 1'b0, 1'b1);
        bus_read(A_ST, r);   check("frm_err_status", r, 32'h0000_0144);
        bus_read(A_RX, r);   check("frm_err_data", r, 32'hC3);
        bus_write(A_CLR, 32'h40);
        bus_read(A_ST, r);   check("frm_clr_status", r, 32'h0000_0005);

        // 17 frames with no reads: the 17th overruns.
        bus_write(A_IE, 32'h1);
        for (int k = 0; k < 17; k++) begin
            b = 8'($urandom);
            if (rx_model.size() < 16) rx_model.push_back(b);
            send_frame(b, 8, 0, 0, 1'b0, 1'b0);
        end
        bus_read(A_ST, r);   check("overrun_status", r, 32'h0000_1086);
        check("overrun_irq", {31'h0, irq}, 32'h1);
        while (rx_model.size() > 0) begin
            bus_read(A_RX, r);
            check("overrun_data", r, {24'h0, rx_model.pop_front()});
        end
        bus_read(A_RX, r);   check("empty_read", r, 32'h0);
        bus_read(A_ST, r);   check("drained_status", r, 32'h0000_0085);
        check("drained_irq", {31'h0, irq}, 32'h0);
        bus_write(A_CLR, 32'h80);
        bus_read(A_ST, r);   check("ovr_clr_status", r, 32'h0000_0005);

        // Fill the TX FIFO (one extra write is ignored), then reset mid-frame.
        bus_write(A_IE, 32'h0);
        for (int k = 0; k < 18; k++) bus_write(A_TX, 32'h00 + k);
        bus_read(A_ST, r);   check("tx_full_status", r, 32'h0010_0019);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx_high", {31'h0, uart_tx}, 32'h1);
        check("rst_rd_data", rd_data, 32'h0);
        rst = 1'b0;
        bus_read(A_ST, r);   check("rst_status", r, 32'h0000_0005);
        bus_read(A_CTRL, r); check("rst_ctrl", r, 32'h0003_0145);
        lows = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("rst_tx_quiet", lows, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
